climate_cmd_ctrl: RTL and testbench

//  Command sequencer and climate controller sitting behind the UART string block.

---
 rtl/climate_cmd_ctrl.sv | 107 ++++++++++
 tb/tb_climate_cmd_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/climate_cmd_ctrl.sv
// climate_cmd_ctrl: validates UART commands into threshold registers or a manual override,
// and drives the fan/humidifier enables with hysteresis in AUTO.
module climate_cmd_ctrl #(
   parameter logic [6:0]  DEF_MAX_TEMP = 7'd25,
   parameter logic [6:0]  DEF_MIN_TEMP = 7'd10,
   parameter logic [6:0]  DEF_MAX_HUM  = 7'd50,
   parameter logic [6:0]  DEF_MIN_HUM  = 7'd20,
   parameter logic [31:0] OVR_TIMEOUT  = 32'd30_000_000
) (
   input  logic       clk_1Mhz,
   input  logic       rst_n,
   input  logic [7:0] chr_cmd,
   input  logic [7:0] chr_val0,
   input  logic [7:0] chr_val1,
   input  logic       rx_msg_done,
   input  logic [7:0] temperature,
   input  logic [7:0] humidity,
   output logic [6:0] max_temp,
   output logic [6:0] min_temp,
   output logic [6:0] max_hum,
   output logic [6:0] min_hum,
   output logic       fan_on,
   output logic       hum_on,
   output logic       manual_mode,
   output logic       cfg_update,
   output logic       cmd_err
);
   localparam logic [2:0] IDLE = 3'd0, LATCH = 3'd1, CHECK = 3'd2, COMMIT = 3'd3, ERR = 3'd4;
   logic [2:0]  state;
   logic        rx_prev;
   logic [7:0]  cmd_q, v0_q, v1_q;
   logic [31:0] timer;
   logic        dig_ok, bit_ok, pass;
   logic [6:0]  val;
   always_comb begin
      dig_ok = v0_q >= 8'h30 && v0_q <= 8'h39 && v1_q >= 8'h30 && v1_q <= 8'h39;
      bit_ok = v0_q[7:1] == 7'h18 && v1_q[7:1] == 7'h18;
      val    = 7'(v0_q[3:0]) * 7'd10 + 7'(v1_q[3:0]);
      pass   = cmd_q == "A" ? dig_ok && val > min_temp :
               cmd_q == "B" ? dig_ok && val < max_temp :
               cmd_q == "C" ? dig_ok && val > min_hum  :
               cmd_q == "D" ? dig_ok && val < max_hum  :
               cmd_q == "L" ? bit_ok : 1'b0;
   end
   always_ff @(posedge clk_1Mhz or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rx_prev     <= 1'b0;
         cmd_q       <= 8'h00;
         v0_q        <= 8'h00;
         v1_q        <= 8'h00;
         timer       <= 32'd0;
         max_temp    <= DEF_MAX_TEMP;
         min_temp    <= DEF_MIN_TEMP;
         max_hum     <= DEF_MAX_HUM;
         min_hum     <= DEF_MIN_HUM;
         fan_on      <= 1'b0;
         hum_on      <= 1'b0;
         manual_mode <= 1'b0;
         cfg_update  <= 1'b0;
         cmd_err     <= 1'b0;
      end else begin
         rx_prev    <= rx_msg_done;
         cfg_update <= 1'b0;
         cmd_err    <= 1'b0;
         // override hold; AUTO only runs once manual_mode has actually dropped
         if (manual_mode) begin
            if (timer != 32'd0) timer <= timer - 32'd1;
            else manual_mode <= 1'b0;
         end else begin
            if (temperature > {1'b0, max_temp}) fan_on <= 1'b1;
            else if (temperature < {1'b0, min_temp}) fan_on <= 1'b0;
            if (humidity < {1'b0, min_hum}) hum_on <= 1'b1;
            else if (humidity > {1'b0, max_hum}) hum_on <= 1'b0;
         end
         case (state)
            IDLE:   if (rx_msg_done && !rx_prev) state <= LATCH;
            LATCH: begin
               cmd_q <= chr_cmd;
               v0_q  <= chr_val0;
               v1_q  <= chr_val1;
               state <= CHECK;
            end
            CHECK:  state <= pass ? COMMIT : ERR;
            COMMIT: begin
               cfg_update <= 1'b1;
               state      <= IDLE;
               if (cmd_q == "A") max_temp <= val;
               if (cmd_q == "B") min_temp <= val;
               if (cmd_q == "C") max_hum  <= val;
               if (cmd_q == "D") min_hum  <= val;
               if (cmd_q == "L") begin
                  manual_mode <= 1'b1;
                  fan_on      <= v0_q[0];
                  hum_on      <= v1_q[0];
                  timer       <= OVR_TIMEOUT;
               end
            end
            ERR: begin
               cmd_err <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_climate_cmd_ctrl.sv
// tb_climate_cmd_ctrl: directed and random command/climate stimulus checked every cycle
// against a cycle-scheduled behavioural model, plus literal expectations.
module tb_climate_cmd_ctrl;
   localparam int OVR = 100;
   logic       clk_1Mhz = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] chr_cmd = 8'h00, chr_val0 = 8'h00, chr_val1 = 8'h00;
   logic       rx_msg_done = 1'b0;
   logic [7:0] temperature = 8'd15, humidity = 8'd30;
   logic [6:0] max_temp, min_temp, max_hum, min_hum;
   logic       fan_on, hum_on, manual_mode, cfg_update, cmd_err;

   climate_cmd_ctrl #(.OVR_TIMEOUT(32'(OVR))) dut (
      .clk_1Mhz(clk_1Mhz), .rst_n(rst_n), .chr_cmd(chr_cmd), .chr_val0(chr_val0),
      .chr_val1(chr_val1), .rx_msg_done(rx_msg_done), .temperature(temperature),
      .humidity(humidity), .max_temp(max_temp), .min_temp(min_temp), .max_hum(max_hum),
      .min_hum(min_hum), .fan_on(fan_on), .hum_on(hum_on), .manual_mode(manual_mode),
      .cfg_update(cfg_update), .cmd_err(cmd_err));

   always #5 clk_1Mhz = ~clk_1Mhz;

   int checks = 0, failures = 0, ncfg = 0, nerr = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // model: a recognised start at edge t latches chars at t+1 and resolves at t+3
   int cyc = 0, start_t = 0, man_end = 0;
   int m_mxt, m_mnt, m_mxh, m_mnh;
   bit m_fan, m_hum, m_man, m_upd, m_err, busy, prev;
   int sc, sa, sb;

   always @(posedge clk_1Mhz or negedge rst_n) begin
      if (!rst_n) begin
         m_mxt = 25; m_mnt = 10; m_mxh = 50; m_mnh = 20;
         m_fan = 0; m_hum = 0; m_man = 0; m_upd = 0; m_err = 0; busy = 0; prev = 0;
      end else begin
         int t, v;
         bit st, nf, nh, nm, ok, dig;
         t = ++cyc;
         st = !busy && rx_msg_done && !prev;
         m_upd = 0; m_err = 0;
         nf = m_fan; nh = m_hum; nm = m_man;
         if (m_man) begin
            if (t == man_end) nm = 0;
         end else begin
            if (int'(temperature) > m_mxt) nf = 1; else if (int'(temperature) < m_mnt) nf = 0;
            if (int'(humidity) < m_mnh) nh = 1; else if (int'(humidity) > m_mxh) nh = 0;
         end
         if (busy && t == start_t + 1) begin
            sc = int'(chr_cmd); sa = int'(chr_val0); sb = int'(chr_val1);
         end
         if (busy && t == start_t + 3) begin
            dig = sa >= 48 && sa <= 57 && sb >= 48 && sb <= 57;
            v = 10 * (sa - 48) + (sb - 48);
            case (sc)
               65: ok = dig && v > m_mnt;
               66: ok = dig && v < m_mxt;
               67: ok = dig && v > m_mnh;
               68: ok = dig && v < m_mxh;
               76: ok = (sa == 48 || sa == 49) && (sb == 48 || sb == 49);
               default: ok = 0;
            endcase
            if (ok) begin
               case (sc)
                  65: m_mxt = v;
                  66: m_mnt = v;
                  67: m_mxh = v;
                  68: m_mnh = v;
                  default: begin nm = 1; nf = (sa == 49); nh = (sb == 49); man_end = t + OVR + 1; end
               endcase
            end
            m_upd = ok; m_err = !ok; busy = 0;
         end
         if (st) begin busy = 1; start_t = t; end
         prev = rx_msg_done;
         m_fan = nf; m_hum = nh; m_man = nm;
      end
   end

   always @(negedge clk_1Mhz) begin
      if (cfg_update) ncfg++;
      if (cmd_err) nerr++;
      if (rst_n) begin
         chk("max_temp", int'(max_temp), m_mxt);
         chk("min_temp", int'(min_temp), m_mnt);
         chk("max_hum", int'(max_hum), m_mxh);
         chk("min_hum", int'(min_hum), m_mnh);
         chk("fan_on", int'(fan_on), int'(m_fan));
         chk("hum_on", int'(hum_on), int'(m_hum));
         chk("manual_mode", int'(manual_mode), int'(m_man));
         chk("cfg_update", int'(cfg_update), int'(m_upd));
         chk("cmd_err", int'(cmd_err), int'(m_err));
         chk("pulse_exclusive", int'(cfg_update && cmd_err), 0);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk_1Mhz); #2; end
   endtask

   // exp: 1 = expect cfg_update, 2 = expect cmd_err, both 3 cycles after the sampling edge
   task automatic send(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b, input int exp);
      int lat, kind;
      chr_cmd = c; chr_val0 = a; chr_val1 = b; rx_msg_done = 1'b0;
      tick(2);
      rx_msg_done = 1'b1;
      @(posedge clk_1Mhz);
      lat = 0; kind = 0;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk_1Mhz); #1;
         if (cfg_update || cmd_err) begin lat = i; kind = cfg_update ? 1 : 2; break; end
      end
      #1;
      chk("pulse_latency", lat, 3);
      chk("pulse_kind", kind, exp);
      tick(2);
   endtask

   function automatic logic [7:0] rch(input bit lb);
      int r;
      r = lb ? int'($urandom_range(2)) : int'($urandom_range(11));
      return r < 10 ? 8'(8'h30 + r) : (r == 10 ? 8'h3a : 8'h2f);
   endfunction

   initial begin
      int c0, e0;
      tick(3);
      rst_n = 1'b1;
      tick(2);
      chk("reset_max_temp", int'(max_temp), 25);
      chk("reset_min_temp", int'(min_temp), 10);
      chk("reset_max_hum", int'(max_hum), 50);
      chk("reset_min_hum", int'(min_hum), 20);
      chk("reset_flags", int'({fan_on, hum_on, manual_mode, cfg_update, cmd_err}), 0);
      temperature = 8'd26; tick(3); chk("auto_fan_set", int'(fan_on), 1);
      temperature = 8'd20; tick(3); chk("auto_fan_hold", int'(fan_on), 1);
      temperature = 8'd9;  tick(3); chk("auto_fan_clear", int'(fan_on), 0);
      humidity = 8'd19; tick(3); chk("auto_hum_set", int'(hum_on), 1);
      humidity = 8'd51; tick(3); chk("auto_hum_clear", int'(hum_on), 0);
      temperature = 8'd15; humidity = 8'd30;
      send("B", "3", "0", 2); chk("B30_min_temp", int'(min_temp), 10);
      send("A", "3", "0", 1); chk("A30_max_temp", int'(max_temp), 30);
      send("A", "0", "5", 2); chk("A05_max_temp", int'(max_temp), 30);
      send("A", "1", "0", 2);
      send("C", "9", "9", 1); chk("C99_max_hum", int'(max_hum), 99);
      send("D", "9", "9", 2);
      send("Q", "1", "1", 2);
      temperature = 8'd5;
      send("L", "1", "0", 1);
      chk("L_fan_on", int'(fan_on), 1);
      chk("L_manual", int'(manual_mode), 1);
      tick(110);
      chk("L_expired_manual", int'(manual_mode), 0);
      chk("L_expired_fan", int'(fan_on), 0);
      temperature = 8'd15;
      send("A", "4", "0", 1);
      c0 = ncfg;
      tick(1000);
      chk("held_rx_no_retrigger", ncfg, c0);
      chr_cmd = "A"; chr_val0 = "5"; chr_val1 = "0"; rx_msg_done = 1'b0;
      tick(2);
      rx_msg_done = 1'b1;
      @(posedge clk_1Mhz);
      @(posedge clk_1Mhz);
      #3 rst_n = 1'b0; rx_msg_done = 1'b0;
      #13 rst_n = 1'b1;
      @(posedge clk_1Mhz); #2;
      c0 = ncfg; e0 = nerr;
      tick(8);
      chk("rst_check_no_cfg", ncfg, c0);
      chk("rst_check_no_err", nerr, e0);
      chk("rst_check_max_temp", int'(max_temp), 25);
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(19) == 0) temperature = 8'($urandom_range(110));
         if ($urandom_range(19) == 0) humidity = 8'($urandom_range(110));
         if ($urandom_range(5) == 0) begin
            rx_msg_done = ~rx_msg_done;
            if (!rx_msg_done) begin
               int r;
               r = int'($urandom_range(11));
               chr_cmd = r < 10 ? 8'(8'h41 + r % 4) : (r == 10 ? 8'h4c : 8'h5a);
               chr_val0 = rch(chr_cmd == 8'h4c);
               chr_val1 = rch(chr_cmd == 8'h4c);
            end
         end
         tick(1);
      end
      rx_msg_done = 1'b0;
      tick(OVR + 10);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
